// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int calc_steps(input int width, input int bpc);
      return width / bpc;
   endfunction

   // Counter must be able to hold STEPS itself (the settle cycle after the last slice).
   function automatic int calc_cnt_width(input int steps);
      return $clog2(steps + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the per-cycle ripple slice.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor resolving BITS_PER_CYCLE bits per clock through a registered carry.
// state | meaning
// IDLE  | ready for operands
// RUN   | resolving slices, then one settle cycle when the counter reaches STEPS
// DONE  | result held until out_ready
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int BPC   = BITS_PER_CYCLE;
   localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
   localparam int CNT_W = calc_cnt_width(STEPS);

   if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_accept;
   logic               w_step;
   logic               w_last;
   logic [BPC-1:0]     w_s;
   logic [BPC:0]       w_c;
   logic [WIDTH-1:0]   w_sum_nxt;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_step   = (r_state == RUN) && (r_cnt != CNT_W'(STEPS));
   assign w_last   = w_step && (r_cnt == CNT_W'(STEPS - 1));

   assign w_c[0] = r_carry;
   for (genvar i = 0; i < BPC; i++) begin : g_fa
      full_adder u_fa (
         .i_a (r_a_sh[i]),
         .i_b (r_b_sh[i]),
         .i_c (w_c[i]),
         .o_s (w_s[i]),
         .o_c (w_c[i+1])
      );
   end

   // Result slices enter from the MSB side so the LSB slice ends up at bit 0.
   if (BPC == WIDTH) begin : g_sum_full
      assign w_sum_nxt = w_s;
   end else begin : g_sum_shift
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:BPC]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_state_nxt = RUN;
         RUN:     if (r_cnt == CNT_W'(STEPS)) w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         IDLE:    in_ready  = 1'b1;
         RUN:     ;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sh  <= a;
         r_b_sh  <= b ^ {WIDTH{sub}};
         r_carry <= sub ? 1'b1 : cin;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_a_sh  <= r_a_sh >> BPC;
         r_b_sh  <= r_b_sh >> BPC;
         r_sum   <= w_sum_nxt;
         r_carry <= w_c[BPC];
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_cout <= w_c[BPC];
            r_ovf  <= w_c[BPC] ^ w_c[BPC-1];
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: directed corner cases on an 8x1 instance, randomized traffic on a 16x4 instance.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       i8_valid, o8_ready_in, o8_valid, i8_ordy, i8_cin, i8_sub, o8_cout, o8_ovf;
   logic [7:0] i8_a, i8_b, o8_sum;

   logic        i16_valid, o16_ready_in, o16_valid, i16_ordy, i16_cin, i16_sub, o16_cout, o16_ovf;
   logic [15:0] i16_a, i16_b, o16_sum;

   int n_cmp = 0;
   int n_err = 0;

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(i8_valid), .in_ready(o8_ready_in),
      .a(i8_a), .b(i8_b), .cin(i8_cin), .sub(i8_sub),
      .out_valid(o8_valid), .out_ready(i8_ordy),
      .sum(o8_sum), .cout(o8_cout), .overflow(o8_ovf)
   );

   serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(i16_valid), .in_ready(o16_ready_in),
      .a(i16_a), .b(i16_b), .cin(i16_cin), .sub(i16_sub),
      .out_valid(o16_valid), .out_ready(i16_ordy),
      .sum(o16_sum), .cout(o16_cout), .overflow(o16_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input int w, input longint ua, input longint ub,
                                 input bit c, input bit s,
                                 output longint r_sum, output bit r_co, output bit r_ov);
      longint m, sa, sb, exact;
      m  = longint'(1) << w;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (s) begin
         r_sum = (ua - ub + m) % m;
         r_co  = (ua >= ub);
         exact = sa - sb;
      end else begin
         r_sum = (ua + ub + c) % m;
         r_co  = (ua + ub + c) >= m;
         exact = sa + sb + c;
      end
      r_ov = (exact >= m / 2) || (exact < -(m / 2));
   endfunction

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                       output int lat);
      i8_a = a; i8_b = b; i8_cin = c; i8_sub = s; i8_valid = 1'b1;
      tick();
      i8_valid = 1'b0;
      lat = 0;
      while (!o8_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic release8();
      i8_ordy = 1'b1;
      tick();
      i8_ordy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_cmp++;
      if ({o8_ready_in, o8_valid, o8_sum, o8_cout, o8_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset8: rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 00 0 0",
                  o8_ready_in, o8_valid, o8_sum, o8_cout, o8_ovf);
      end
      n_cmp++;
      if ({o16_ready_in, o16_valid, o16_sum, o16_cout, o16_ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset16: rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 0000 0 0",
                  o16_ready_in, o16_valid, o16_sum, o16_cout, o16_ovf);
      end
   endtask

   // Directed vector on the 8-bit instance: latency, result, then release.
   task automatic test_vec8(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic s,
                            input logic [7:0] ex_sum, input logic ex_co, input logic ex_ov);
      int lat;
      n_cmp++;
      if (o8_ready_in !== 1'b1) begin
         n_err++;
         $display("FAIL %s_ready: in_ready=%b want 1", name, o8_ready_in);
      end
      run8(a, b, c, s, lat);
      n_cmp++;
      if (lat !== 9) begin
         n_err++;
         $display("FAIL %s_latency: got %0d want 9", name, lat);
      end
      n_cmp++;
      if ({o8_sum, o8_cout, o8_ovf} !== {ex_sum, ex_co, ex_ov}) begin
         n_err++;
         $display("FAIL %s_result: sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                  name, o8_sum, o8_cout, o8_ovf, ex_sum, ex_co, ex_ov);
      end
      release8();
      n_cmp++;
      if ({o8_ready_in, o8_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL %s_release: rdy=%b vld=%b want 1 0", name, o8_ready_in, o8_valid);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [7:0] held;
      run8(8'h5A, 8'h33, 1'b0, 1'b0, lat);
      held = o8_sum;
      n_cmp++;
      if (held !== 8'h8D) begin
         n_err++;
         $display("FAIL bp_result: sum=%h want 8d", held);
      end
      for (int i = 0; i < 5; i++) begin
         i8_valid = ~i8_valid;
         i8_a = 8'($urandom); i8_b = 8'($urandom);
         i8_sub = 1'($urandom); i8_cin = 1'($urandom);
         tick();
         n_cmp++;
         if ({o8_valid, o8_ready_in, o8_sum} !== {1'b1, 1'b0, held}) begin
            n_err++;
            $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h want 1 0 %h",
                     i, o8_valid, o8_ready_in, o8_sum, held);
         end
      end
      i8_valid = 1'b0;
      release8();
      n_cmp++;
      if ({o8_ready_in, o8_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL bp_release: rdy=%b vld=%b want 1 0", o8_ready_in, o8_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      i8_a = 8'hAA; i8_b = 8'h55; i8_cin = 1'b1; i8_sub = 1'b0; i8_valid = 1'b1;
      tick();
      i8_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({o8_ready_in, o8_valid, o8_sum, o8_cout, o8_ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL midrun_reset: rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 00 0 0",
                  o8_ready_in, o8_valid, o8_sum, o8_cout, o8_ovf);
      end
      test_vec8("after_reset", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
   endtask

   task automatic test_random8();
      longint es;
      bit eco, eov;
      int lat;
      logic [7:0] a, b;
      logic c, s;
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom); b = 8'($urandom); c = 1'($urandom); s = 1'($urandom);
         model(8, longint'(a), longint'(b), c, s, es, eco, eov);
         run8(a, b, c, s, lat);
         n_cmp++;
         if (lat !== 9 || {o8_sum, o8_cout, o8_ovf} !== {8'(es), eco, eov}) begin
            n_err++;
            $display("FAIL rand8_%0d: a=%h b=%h c=%b s=%b lat=%0d sum=%h co=%b ov=%b want lat=9 sum=%h co=%b ov=%b",
                     i, a, b, c, s, lat, o8_sum, o8_cout, o8_ovf, 8'(es), eco, eov);
         end
         release8();
      end
   endtask

   task automatic test_random16();
      longint es;
      bit eco, eov;
      int lat, hold;
      logic [15:0] a, b;
      logic c, s;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
         if (i % 7 == 0) b = a;
         model(16, longint'(a), longint'(b), c, s, es, eco, eov);
         n_cmp++;
         if (o16_ready_in !== 1'b1) begin
            n_err++;
            $display("FAIL rand16_%0d_ready: in_ready=%b want 1", i, o16_ready_in);
         end
         i16_a = a; i16_b = b; i16_cin = c; i16_sub = s; i16_valid = 1'b1;
         tick();
         i16_valid = 1'b0;
         i16_a = 16'($urandom); i16_b = 16'($urandom);
         lat = 0;
         while (!o16_valid && lat < 40) begin
            tick();
            lat++;
         end
         n_cmp++;
         if (lat !== 5) begin
            n_err++;
            $display("FAIL rand16_%0d_latency: got %0d want 5", i, lat);
         end
         hold = $urandom_range(0, 3);
         for (int k = 0; k < hold; k++) tick();
         n_cmp++;
         if ({o16_valid, o16_sum, o16_cout, o16_ovf} !== {1'b1, 16'(es), eco, eov}) begin
            n_err++;
            $display("FAIL rand16_%0d: a=%h b=%h c=%b s=%b vld=%b sum=%h co=%b ov=%b want 1 %h %b %b",
                     i, a, b, c, s, o16_valid, o16_sum, o16_cout, o16_ovf, 16'(es), eco, eov);
         end
         i16_ordy = 1'b1;
         tick();
         i16_ordy = 1'b0;
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   initial begin
      i8_valid = 1'b0; i8_ordy = 1'b0; i8_a = '0; i8_b = '0; i8_cin = 1'b0; i8_sub = 1'b0;
      i16_valid = 1'b0; i16_ordy = 1'b0; i16_a = '0; i16_b = '0; i16_cin = 1'b0; i16_sub = 1'b0;
      #1;
      test_reset();
      test_vec8("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      test_vec8("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
      test_vec8("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      test_vec8("sub_cin",   8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
      test_vec8("add_cin",   8'h0F, 8'h10, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
      test_vec8("sub_borrow",8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      test_backpressure();
      test_reset_mid_run();
      test_random8();
      test_random16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
